// File: rtl/mac_accum_seq_pkg.sv
// Shared definitions for the MAC accumulator sequencer: FSM states, default widths
// and the width rule of the multiply-accumulate step.
package mac_accum_seq_pkg;

  localparam int N_DEF     = 32;
  localparam int LEN_W_DEF = 8;

  localparam int PROD_W_DEF = 2 * N_DEF;
  localparam int SUM_W_DEF  = N_DEF + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The product keeps every bit. The sum is one bit wider, so it cannot overflow.
  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

  function automatic int sum_w(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/mac_accum_seq_mac.sv
// Combinational fixed-point MAC stage: Y = floor((hi(A*X) + Y0) / 2), bit-exact.
module mac_accum_seq_mac
  import mac_accum_seq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic signed [N-1:0] A,
  input  logic signed [N-1:0] X,
  input  logic signed [N-1:0] Y0,
  output logic signed [N-1:0] Y
);

  localparam int PW = prod_w(N);
  localparam int SW = sum_w(N);

  logic signed [PW-1:0] p;
  logic signed [N-1:0]  hi;
  logic signed [SW-1:0] s;
  logic                 unused_bits;

  assign p  = A * X;
  assign hi = p[PW-1:N];
  assign s  = {hi[N-1], hi} + {Y0[N-1], Y0};
  // Dropping s[0] is the arithmetic shift right (floor). The low product half is discarded.
  assign Y  = s[N:1];

  assign unused_bits = ^{p[N-1:0], s[0]};

endmodule

// File: rtl/mac_accum_seq.sv
// Sequencer that streams (a, x) pairs through the MAC stage, accumulates the result
// in acc and hands one result per vector to the consumer.
module mac_accum_seq
  import mac_accum_seq_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [N-1:0]     y_init,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     y
);

  state_e           state;
  logic [N-1:0]     acc;
  logic [N-1:0]     acc_next;
  logic [LEN_W-1:0] cnt;

  mac_accum_seq_mac #(.N(N)) u_mac (
    .A  (a),
    .X  (x),
    .Y0 (acc),
    .Y  (acc_next)
  );

  // In RUN, in_ready is 1, so in_valid alone marks a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= y_init;
            if (len != '0) begin
              cnt   <= len;
              state <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            acc <= acc_next;
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign y         = acc;

endmodule

// File: tb/tb_mac_accum_seq.sv
// Self-checking bench for mac_accum_seq: a table of single-step vectors, hand-written
// stall, back-pressure and reset sequences, and random vectors against an arithmetic model.
module tb_mac_accum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [31:0] y_init;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] yinit;
    logic [31:0] av;
    logic [31:0] xv;
    logic [31:0] expy;
  } vec_t;

  vec_t table_v[6];

  always #5 clk = ~clk;

  mac_accum_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .y_init    (y_init),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  // The reference uses plain 64-bit arithmetic: floor((floor(a*x / 2^32) + acc) / 2).
  function automatic logic [31:0] modelStep(input logic [31:0] acc_in, input logic [31:0] av,
                                            input logic [31:0] xv);
    longint sa, sx, sacc, p, hi, s;
    sa   = longint'($signed(av));
    sx   = longint'($signed(xv));
    sacc = longint'($signed(acc_in));
    p    = sa * sx;
    hi   = p >>> 32;
    s    = hi + sacc;
    return 32'(s >>> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic startVector(input logic [7:0] l, input logic [31:0] yi);
    checkOutput("idle_busy", {31'b0, busy}, 32'd0);
    start  = 1'b1;
    len    = l;
    y_init = yi;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Waits a bounded time for in_ready, then holds one pair for a single cycle.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] xv);
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    checkOutput("in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a        = av;
    x        = xv;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finishVector(input string name, input logic [31:0] expy, input int hold);
    checkOutput({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({name, "_y"}, y, expy);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({name, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({name, "_hold_y"}, y, expy);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({name, "_idle"}, {30'b0, busy, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_acc;
    int          n;

    table_v[0] = '{"single_step", 32'h10000000, 32'h40000000, 32'h40000000, 32'h10000000};
    table_v[1] = '{"sum_width",   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h5FFFFFFF};
    table_v[2] = '{"neg_floor",   32'h00000000, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF};
    table_v[3] = '{"min_by_min",  32'h80000000, 32'h80000000, 32'h80000000, 32'hE0000000};
    table_v[4] = '{"mixed_sign",  32'h20000000, 32'h40000000, 32'hC0000000, 32'h08000000};
    table_v[5] = '{"small_ops",   32'h00000005, 32'h00000002, 32'h00000003, 32'h00000002};

    rst = 1'b1; start = 1'b0; len = '0; y_init = '0;
    in_valid = 1'b0; a = '0; x = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_flags", {29'b0, busy, in_ready, out_valid}, 32'd0);
    checkOutput("reset_y", y, 32'd0);

    for (int i = 0; i < 6; i++) begin
      startVector(8'd1, table_v[i].yinit);
      checkOutput({table_v[i].name, "_early"}, {31'b0, out_valid}, 32'd0);
      applyStimulus(table_v[i].av, table_v[i].xv);
      finishVector(table_v[i].name, table_v[i].expy, 0);
      @(negedge clk);
    end

    // Input gaps between two pairs must leave in_ready high and acc untouched.
    startVector(8'd2, 32'h0);
    applyStimulus(32'h40000000, 32'h40000000);
    for (int i = 0; i < 3; i++) begin
      checkOutput("gap_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("gap_acc", y, 32'h08000000);
      checkOutput("gap_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end
    applyStimulus(32'h40000000, 32'h40000000);
    finishVector("stall", 32'h0C000000, 0);
    @(negedge clk);

    // Zero length goes straight to DONE; a start pulse there must be ignored.
    startVector(8'd0, 32'h12345678);
    checkOutput("zero_len_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    start = 1'b1; len = 8'd3; y_init = 32'h0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_in_done_ready", {31'b0, in_ready}, 32'd0);
    finishVector("backpressure", 32'h12345678, 3);
    @(negedge clk);

    // Reset in the middle of a vector discards the partial sum.
    startVector(8'd4, 32'h11111111);
    applyStimulus(32'h40000000, 32'h40000000);
    applyStimulus(32'h40000000, 32'h40000000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrun_rst_flags", {29'b0, busy, in_ready, out_valid}, 32'd0);
    checkOutput("midrun_rst_y", y, 32'd0);
    startVector(8'd1, 32'h10000000);
    applyStimulus(32'h40000000, 32'h40000000);
    finishVector("after_rst", 32'h10000000, 0);
    @(negedge clk);

    for (int v = 0; v < 25; v++) begin
      n       = int'($urandom_range(0, 6));
      exp_acc = $urandom;
      startVector(8'(n), exp_acc);
      for (int k = 0; k < n; k++) begin
        logic [31:0] ra, rx;
        ra = $urandom;
        rx = $urandom;
        if (v % 4 == 0) begin
          ra = {{16{ra[31]}}, ra[15:0]};
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        exp_acc = modelStep(exp_acc, ra, rx);
        applyStimulus(ra, rx);
      end
      finishVector("random", exp_acc, int'($urandom_range(0, 2)));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
